// File: rtl/post_alu_writeback_if.sv
// Instruction, data-memory and register-file write signals of the post-ALU writeback stage.
// The stage itself connects through the slave modport; its environment uses master.
interface post_alu_writeback_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] ALU_OUT;
  logic [DATA_W-1:0] PC;
  logic [DATA_W-1:0] D_RegSW;
  logic [REG_AW-1:0] D_WriteReg;
  logic              C_RegWrite;
  logic              C_MemRead;
  logic              C_MemWrite;
  logic [1:0]        C_MemToReg;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              wb_done;
  logic              mem_err;

  modport slave (
    input  in_valid, ALU_OUT, PC, D_RegSW, D_WriteReg,
           C_RegWrite, C_MemRead, C_MemWrite, C_MemToReg,
           mem_ack, mem_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
           rf_we, rf_waddr, rf_wdata, wb_done, mem_err
  );

  modport master (
    output in_valid, ALU_OUT, PC, D_RegSW, D_WriteReg,
           C_RegWrite, C_MemRead, C_MemWrite, C_MemToReg,
           mem_ack, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
           rf_we, rf_waddr, rf_wdata, wb_done, mem_err
  );
endinterface

// File: rtl/post_alu_writeback.sv
// Retires one ALU result per instruction: optional data-memory load/store handshake,
// writeback source select and a single register-file write, all outputs registered.
module post_alu_writeback #(
  parameter int DATA_W      = 16,
  parameter int REG_AW      = 4,
  parameter int PC_INC      = 2,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                clk,
  input logic                reset,
  post_alu_writeback_if.slave bus
);

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, MEM, WB} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              ack_hit, tmo_hit, accept;

  // Instruction fields captured on accept
  logic              regwrite_p0, load_p0, store_p0;
  logic [1:0]        m2r_p0;
  logic [DATA_W-1:0] pc_p0;
  logic [REG_AW-1:0] waddr_p0;

  logic              f_regwrite, f_store;
  logic [1:0]        f_m2r;
  logic [DATA_W-1:0] f_alu, f_pc, f_ld;
  logic [REG_AW-1:0] f_waddr;
  logic              we_nxt;
  logic [DATA_W-1:0] wdata_nxt;

  // Link address wraps modulo 2^DATA_W; the reserved select writes zero.
  function automatic logic [DATA_W-1:0] wb_data(input logic [1:0] m2r,
                                                input logic [DATA_W-1:0] alu,
                                                input logic [DATA_W-1:0] ld,
                                                input logic [DATA_W-1:0] pc);
    case (m2r)
      2'b00:   return alu;
      2'b01:   return ld;
      2'b10:   return pc + DATA_W'(PC_INC);
      default: return '0;
    endcase
  endfunction

  assign accept = (state == IDLE) && bus.in_valid;

  always_comb begin
    state_nxt = state;
    ack_hit   = 1'b0;
    tmo_hit   = 1'b0;
    unique case (state)
      IDLE: if (bus.in_valid) state_nxt = (bus.C_MemRead || bus.C_MemWrite) ? MEM : WB;
      MEM: begin
        if (bus.mem_ack) begin
          ack_hit   = 1'b1;
          state_nxt = WB;
        end else if ((MEM_TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          tmo_hit   = 1'b1;
          state_nxt = WB;
        end
      end
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU-only instructions go straight from IDLE to WB, so they select from the live inputs.
  always_comb begin
    f_regwrite = regwrite_p0;
    f_store    = store_p0;
    f_m2r      = m2r_p0;
    f_alu      = bus.mem_addr;
    f_pc       = pc_p0;
    f_waddr    = waddr_p0;
    f_ld       = '0;
    if (accept) begin
      f_regwrite = bus.C_RegWrite;
      f_store    = bus.C_MemWrite;
      f_m2r      = bus.C_MemToReg;
      f_alu      = bus.ALU_OUT;
      f_pc       = bus.PC;
      f_waddr    = bus.D_WriteReg;
    end else if (ack_hit && load_p0 && !store_p0) begin
      f_ld = bus.mem_rdata;
    end
    we_nxt    = f_regwrite && !f_store && !tmo_hit;
    wdata_nxt = wb_data(f_m2r, f_alu, f_ld, f_pc);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Stage p0 -> registered control outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.in_ready <= 1'b1;
      bus.mem_req  <= 1'b0;
      bus.mem_we   <= 1'b0;
      bus.rf_we    <= 1'b0;
      bus.wb_done  <= 1'b0;
      bus.mem_err  <= 1'b0;
      cnt          <= '0;
    end else begin
      bus.in_ready <= (state_nxt == IDLE);
      bus.mem_req  <= (state_nxt == MEM);
      bus.mem_we   <= (state_nxt == MEM) && f_store;
      bus.rf_we    <= (state_nxt == WB) && we_nxt;
      bus.wb_done  <= (state_nxt == WB);
      if (tmo_hit) bus.mem_err <= 1'b1;
      cnt <= ((state == MEM) && (state_nxt == MEM)) ? cnt + 1'b1 : '0;
    end
  end

  // Stage p0 -> latched fields and writeback data
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.rf_waddr  <= '0;
      bus.rf_wdata  <= '0;
      regwrite_p0   <= 1'b0;
      load_p0       <= 1'b0;
      store_p0      <= 1'b0;
      m2r_p0        <= 2'b00;
      pc_p0         <= '0;
      waddr_p0      <= '0;
    end else begin
      if (accept) begin
        bus.mem_addr  <= bus.ALU_OUT;
        bus.mem_wdata <= bus.D_RegSW;
        regwrite_p0   <= bus.C_RegWrite;
        load_p0       <= bus.C_MemRead;
        store_p0      <= bus.C_MemWrite;
        m2r_p0        <= bus.C_MemToReg;
        pc_p0         <= bus.PC;
        waddr_p0      <= bus.D_WriteReg;
      end
      if (state_nxt == WB) begin
        bus.rf_waddr <= f_waddr;
        bus.rf_wdata <= wdata_nxt;
      end
    end
  end

endmodule

// File: tb/tb_post_alu_writeback.sv
// Transaction-level bench for post_alu_writeback: each instruction is driven, the memory
// side is answered with a chosen ack latency, and outputs are compared to a reference model.
module tb_post_alu_writeback;

  localparam int DATA_W = 16;
  localparam int REG_AW = 4;
  localparam int PC_INC = 2;
  localparam int TMO    = 15;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic err_exp = 1'b0;

  post_alu_writeback_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

  post_alu_writeback #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .PC_INC(PC_INC), .MEM_TIMEOUT(TMO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_wdata(input logic [1:0] m2r, input logic rd, input logic wr,
                                               input logic [15:0] alu, input logic [15:0] pc,
                                               input logic [15:0] rdata);
    case (m2r)
      2'd0:    return alu;
      2'd1:    return (rd && !wr) ? rdata : 16'h0000;
      2'd2:    return 16'((int'(pc) + PC_INC) % 65536);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble_inputs();
    bus.ALU_OUT    = 16'($urandom);
    bus.PC         = 16'($urandom);
    bus.D_RegSW    = 16'($urandom);
    bus.D_WriteReg = 4'($urandom);
    bus.C_RegWrite = 1'($urandom);
    bus.C_MemRead  = 1'($urandom);
    bus.C_MemWrite = 1'($urandom);
    bus.C_MemToReg = 2'($urandom);
  endtask

  // ack_lat: MEM cycle (1-based) in which mem_ack is given; 0 means never.
  task automatic run_instr(input logic rw, input logic rd, input logic wr, input logic [1:0] m2r,
                           input logic [15:0] alu, input logic [15:0] pc, input logic [15:0] sw,
                           input logic [3:0] wa, input logic [15:0] rdata, input int ack_lat);
    int   cyc;
    logic done, timed_out, exp_we;
    check("rdy_idle", bus.in_ready, 1'b1);
    bus.in_valid   = 1'b1;
    bus.ALU_OUT    = alu;
    bus.PC         = pc;
    bus.D_RegSW    = sw;
    bus.D_WriteReg = wa;
    bus.C_RegWrite = rw;
    bus.C_MemRead  = rd;
    bus.C_MemWrite = wr;
    bus.C_MemToReg = m2r;
    bus.mem_ack    = 1'($urandom);
    bus.mem_rdata  = 16'($urandom);
    step();
    bus.in_valid = 1'b0;
    bus.mem_ack  = 1'b0;
    scramble_inputs();
    timed_out = 1'b0;
    if (rd || wr) begin
      cyc  = 0;
      done = 1'b0;
      while (!done) begin
        cyc++;
        check("mem_req", bus.mem_req, 1'b1);
        check("mem_addr", bus.mem_addr, alu);
        check("mem_wdata", bus.mem_wdata, sw);
        check("mem_we", bus.mem_we, wr);
        check("rdy_busy", bus.in_ready, 1'b0);
        check("rf_we_mem", bus.rf_we, 1'b0);
        if (cyc == ack_lat) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = rdata;
          done = 1'b1;
        end else begin
          bus.mem_ack   = 1'b0;
          bus.mem_rdata = 16'($urandom);
          if (cyc == TMO) begin
            done      = 1'b1;
            timed_out = 1'b1;
          end
        end
        step();
        bus.mem_ack = 1'b0;
      end
    end
    if (timed_out) err_exp = 1'b1;
    exp_we = rw && !wr && !timed_out;
    check("wb_done", bus.wb_done, 1'b1);
    check("rf_we", bus.rf_we, exp_we);
    check("mem_req_wb", bus.mem_req, 1'b0);
    check("rdy_wb", bus.in_ready, 1'b0);
    check("mem_err", bus.mem_err, err_exp);
    if (exp_we) begin
      check("rf_waddr", bus.rf_waddr, wa);
      check("rf_wdata", bus.rf_wdata, model_wdata(m2r, rd, wr, alu, pc, rdata));
    end
    bus.mem_ack   = 1'($urandom);
    bus.mem_rdata = 16'($urandom);
    step();
    bus.mem_ack = 1'b0;
    check("wb_done_off", bus.wb_done, 1'b0);
    check("rf_we_off", bus.rf_we, 1'b0);
    check("rdy_back", bus.in_ready, 1'b1);
  endtask

  task automatic reset_mid_mem();
    bus.in_valid   = 1'b1;
    bus.ALU_OUT    = 16'h0100;
    bus.D_WriteReg = 4'd7;
    bus.C_RegWrite = 1'b1;
    bus.C_MemRead  = 1'b1;
    bus.C_MemWrite = 1'b0;
    bus.C_MemToReg = 2'b01;
    bus.mem_ack    = 1'b0;
    step();
    bus.in_valid = 1'b0;
    check("rst_mid_req1", bus.mem_req, 1'b1);
    step();
    check("rst_mid_req2", bus.mem_req, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    err_exp = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'hDEAD;
    check("rst_mid_req", bus.mem_req, 1'b0);
    check("rst_mid_rdy", bus.in_ready, 1'b1);
    check("rst_mid_rfwe", bus.rf_we, 1'b0);
    check("rst_mid_done", bus.wb_done, 1'b0);
    check("rst_mid_err", bus.mem_err, 1'b0);
    step();
    bus.mem_ack = 1'b0;
    check("rst_ack_rfwe", bus.rf_we, 1'b0);
    check("rst_ack_done", bus.wb_done, 1'b0);
    check("rst_ack_req", bus.mem_req, 1'b0);
    check("rst_ack_rdy", bus.in_ready, 1'b1);
  endtask

  initial begin
    logic rd, wr;
    int   r, lat;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    scramble_inputs();
    repeat (3) step();
    reset = 1'b0;
    check("rst_rdy", bus.in_ready, 1'b1);
    check("rst_req", bus.mem_req, 1'b0);
    check("rst_we", bus.mem_we, 1'b0);
    check("rst_addr", bus.mem_addr, 16'h0);
    check("rst_wdata", bus.mem_wdata, 16'h0);
    check("rst_rfwe", bus.rf_we, 1'b0);
    check("rst_rfaddr", bus.rf_waddr, 4'h0);
    check("rst_rfdata", bus.rf_wdata, 16'h0);
    check("rst_done", bus.wb_done, 1'b0);
    check("rst_err", bus.mem_err, 1'b0);

    run_instr(1, 0, 0, 2'b00, 16'h1234, 16'h0010, 16'h0000, 4'd3, 16'h0000, 0);
    run_instr(1, 1, 0, 2'b01, 16'h0040, 16'h0012, 16'h1111, 4'd5, 16'hBEEF, 3);
    run_instr(1, 0, 1, 2'b00, 16'h0080, 16'h0014, 16'hA5A5, 4'd6, 16'h0000, 1);
    run_instr(1, 0, 0, 2'b10, 16'h5555, 16'hFFFF, 16'h0000, 4'd14, 16'h0000, 0);
    run_instr(1, 1, 1, 2'b01, 16'h0090, 16'h0016, 16'h7777, 4'd2, 16'hCAFE, 2);
    run_instr(1, 0, 0, 2'b01, 16'h4321, 16'h0018, 16'h0000, 4'd4, 16'h0000, 0);
    run_instr(1, 0, 0, 2'b11, 16'h4321, 16'h001A, 16'h0000, 4'd8, 16'h0000, 0);
    run_instr(1, 1, 0, 2'b01, 16'h00C0, 16'h001C, 16'h0000, 4'd9, 16'h1357, 15);
    run_instr(1, 1, 0, 2'b01, 16'h00E0, 16'h001E, 16'h0000, 4'd1, 16'h2468, 0);
    run_instr(1, 0, 0, 2'b00, 16'h0F0F, 16'h0020, 16'h0000, 4'd0, 16'h0000, 0);
    reset_mid_mem();

    for (int i = 0; i < 200; i++) begin
      r  = $urandom_range(0, 5);
      rd = (r == 0) || (r == 2);
      wr = (r == 1) || (r == 2);
      r  = $urandom_range(0, 9);
      lat = (r == 0) ? 0 : (r == 1) ? TMO : $urandom_range(1, 4);
      run_instr(1'($urandom), rd, wr, 2'($urandom), 16'($urandom), 16'($urandom),
                16'($urandom), 4'($urandom), 16'($urandom), lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
